// File: rtl/memgame_pkg.sv
// ---------------------------------------------------------------------------
// memgame_pkg
// Shared types and constants for the memory-game turn sequencer.
//   state_t   : turn FSM states
//   result_t  : game result codes driven on turn_sequencer.result
//   NUM_PAIRS_DEF : default number of card pairs on the board
//   max_u     : constant-expression helper for sizing the shared timer
//   grade     : maps final scores onto a result code
// ---------------------------------------------------------------------------
package memgame_pkg;

   localparam int unsigned NUM_PAIRS_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PICK1 = 3'd1,
      ST_PICK2 = 3'd2,
      ST_CHECK = 3'd3,
      ST_SHOW  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      RES_PLAY = 2'b00,
      RES_P0   = 2'b01,
      RES_P1   = 2'b10,
      RES_TIE  = 2'b11
   } result_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic result_t grade(input logic [3:0] s0, input logic [3:0] s1);
      if (s0 > s1) return RES_P0;
      if (s0 < s1) return RES_P1;
      return RES_TIE;
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// ---------------------------------------------------------------------------
// cycle_timer
// Loadable down-counter shared by the SHOW dwell and the per-pick timeout.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset, clears the count
//   i_load     : load i_value this cycle (takes priority over counting)
//   i_value    : reload value
//   o_expired  : high during the last cycle of a loaded interval
// A load of N keeps the owner waiting exactly N cycles: o_expired rises while
// the count is 1, so the owner's transition lands on the N-th edge.
// The count stops at zero and never wraps.
// ---------------------------------------------------------------------------
module cycle_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_value,
   output logic             o_expired
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - WIDTH'(1);
      end
   end

   assign o_expired = (r_cnt <= WIDTH'(1));

endmodule

// File: rtl/turn_sequencer.sv
// ---------------------------------------------------------------------------
// turn_sequencer
// Two-player memory-game turn controller: accepts two picks per turn, scores
// matches, shows mismatches for a fixed time, passes the turn on idle
// timeout and grades the game when every pair is found.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-low reset
//   start      : pulse, begins/restarts a game (IDLE or DONE only)
//   select     : pulse, pick the card under the cursor
//   card_idx   : cursor position
//   card_sym   : symbol at card_idx
//   card_free  : card at card_idx is face-down and unmatched
//   player     : active player
//   reveal     : pulse, turn card_idx face-up
//   hide       : pulse, turn sel1/sel2 face-down
//   matched    : pulse, mark sel1/sel2 as matched
//   sel1, sel2 : first and second pick indices
//   score0/1   : pairs won per player
//   result     : 00 playing/idle, 01 p0 wins, 10 p1 wins, 11 tie
// All outputs come straight from registers; pulses appear on the same edge
// that updates the indices/scores they refer to.
// ---------------------------------------------------------------------------
module turn_sequencer
   import memgame_pkg::*;
#(
   parameter int unsigned NUM_PAIRS      = NUM_PAIRS_DEF,
   parameter int unsigned SHOW_CYCLES    = 25_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       select,
   input  logic [3:0] card_idx,
   input  logic [2:0] card_sym,
   input  logic       card_free,
   output logic       player,
   output logic       reveal,
   output logic       hide,
   output logic       matched,
   output logic [3:0] sel1,
   output logic [3:0] sel2,
   output logic [3:0] score0,
   output logic [3:0] score1,
   output logic [1:0] result
);

   localparam int unsigned   TW       = $clog2(max_u(SHOW_CYCLES, TIMEOUT_CYCLES) + 1);
   localparam logic [TW-1:0] LP_SHOW  = TW'(SHOW_CYCLES);
   localparam logic [TW-1:0] LP_TOUT  = TW'(TIMEOUT_CYCLES);
   localparam logic [3:0]    LP_PAIRS = 4'(NUM_PAIRS);

   state_t     r_state,   w_state_nxt;
   logic       r_player,  w_player_nxt;
   logic       r_reveal,  w_reveal_nxt;
   logic       r_hide,    w_hide_nxt;
   logic       r_matched, w_matched_nxt;
   logic [3:0] r_sel1,    w_sel1_nxt;
   logic [3:0] r_sel2,    w_sel2_nxt;
   logic [2:0] r_sym1,    w_sym1_nxt;
   logic [2:0] r_sym2,    w_sym2_nxt;
   logic [3:0] r_score0,  w_score0_nxt;
   logic [3:0] r_score1,  w_score1_nxt;
   logic [3:0] r_pairs,   w_pairs_nxt;
   result_t    r_result,  w_result_nxt;

   logic          w_tmr_load;
   logic [TW-1:0] w_tmr_value;
   logic          w_expired;
   logic          w_pick1_ok;
   logic          w_pick2_ok;
   logic [3:0]    w_score0_inc;
   logic [3:0]    w_score1_inc;
   logic [3:0]    w_pairs_inc;

   cycle_timer #(
      .WIDTH (TW)
   ) u_timer (
      .i_clk     (clk),
      .i_rst_n   (rst),
      .i_load    (w_tmr_load),
      .i_value   (w_tmr_value),
      .o_expired (w_expired)
   );

   assign w_pick1_ok   = select && card_free;
   assign w_pick2_ok   = select && card_free && (card_idx != r_sel1);
   assign w_score0_inc = (r_score0 < LP_PAIRS) ? r_score0 + 4'd1 : r_score0;
   assign w_score1_inc = (r_score1 < LP_PAIRS) ? r_score1 + 4'd1 : r_score1;
   assign w_pairs_inc  = r_pairs + 4'd1;

   always_comb begin
      w_state_nxt   = r_state;
      w_player_nxt  = r_player;
      w_reveal_nxt  = 1'b0;
      w_hide_nxt    = 1'b0;
      w_matched_nxt = 1'b0;
      w_sel1_nxt    = r_sel1;
      w_sel2_nxt    = r_sel2;
      w_sym1_nxt    = r_sym1;
      w_sym2_nxt    = r_sym2;
      w_score0_nxt  = r_score0;
      w_score1_nxt  = r_score1;
      w_pairs_nxt   = r_pairs;
      w_result_nxt  = r_result;
      w_tmr_load    = 1'b0;
      w_tmr_value   = LP_TOUT;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_score0_nxt = '0;
               w_score1_nxt = '0;
               w_pairs_nxt  = '0;
               w_player_nxt = 1'b0;
               w_result_nxt = RES_PLAY;
               w_state_nxt  = ST_PICK1;
               w_tmr_load   = 1'b1;
            end
         end

         // A valid pick is tested before expiry so it wins a same-cycle race.
         ST_PICK1: begin
            if (w_pick1_ok) begin
               w_sel1_nxt   = card_idx;
               w_sym1_nxt   = card_sym;
               w_reveal_nxt = 1'b1;
               w_state_nxt  = ST_PICK2;
               w_tmr_load   = 1'b1;
            end else if (w_expired) begin
               w_player_nxt = ~r_player;
               w_tmr_load   = 1'b1;
            end
         end

         ST_PICK2: begin
            if (w_pick2_ok) begin
               w_sel2_nxt   = card_idx;
               w_sym2_nxt   = card_sym;
               w_reveal_nxt = 1'b1;
               w_state_nxt  = ST_CHECK;
            end else if (w_expired) begin
               // sel2 mirrors sel1 so the hide pulse only flips the one open card
               w_sel2_nxt   = r_sel1;
               w_hide_nxt   = 1'b1;
               w_player_nxt = ~r_player;
               w_state_nxt  = ST_PICK1;
               w_tmr_load   = 1'b1;
            end
         end

         ST_CHECK: begin
            if (r_sym1 == r_sym2) begin
               w_matched_nxt = 1'b1;
               w_pairs_nxt   = w_pairs_inc;
               if (r_player) w_score1_nxt = w_score1_inc;
               else          w_score0_nxt = w_score0_inc;
               if (w_pairs_inc == LP_PAIRS) begin
                  w_state_nxt  = ST_DONE;
                  w_result_nxt = r_player ? grade(r_score0, w_score1_inc)
                                          : grade(w_score0_inc, r_score1);
               end else begin
                  w_state_nxt  = ST_PICK1;
                  w_tmr_load   = 1'b1;
               end
            end else begin
               w_state_nxt = ST_SHOW;
               w_tmr_load  = 1'b1;
               w_tmr_value = LP_SHOW;
            end
         end

         ST_SHOW: begin
            if (w_expired) begin
               w_hide_nxt   = 1'b1;
               w_player_nxt = ~r_player;
               w_state_nxt  = ST_PICK1;
               w_tmr_load   = 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_player  <= 1'b0;
         r_reveal  <= 1'b0;
         r_hide    <= 1'b0;
         r_matched <= 1'b0;
         r_sel1    <= '0;
         r_sel2    <= '0;
         r_sym1    <= '0;
         r_sym2    <= '0;
         r_score0  <= '0;
         r_score1  <= '0;
         r_pairs   <= '0;
         r_result  <= RES_PLAY;
      end else begin
         r_state   <= w_state_nxt;
         r_player  <= w_player_nxt;
         r_reveal  <= w_reveal_nxt;
         r_hide    <= w_hide_nxt;
         r_matched <= w_matched_nxt;
         r_sel1    <= w_sel1_nxt;
         r_sel2    <= w_sel2_nxt;
         r_sym1    <= w_sym1_nxt;
         r_sym2    <= w_sym2_nxt;
         r_score0  <= w_score0_nxt;
         r_score1  <= w_score1_nxt;
         r_pairs   <= w_pairs_nxt;
         r_result  <= w_result_nxt;
      end
   end

   assign player  = r_player;
   assign reveal  = r_reveal;
   assign hide    = r_hide;
   assign matched = r_matched;
   assign sel1    = r_sel1;
   assign sel2    = r_sel2;
   assign score0  = r_score0;
   assign score1  = r_score1;
   assign result  = r_result;

endmodule
